oh_fifo_sync_dp: RTL and testbench

//  Single-clock FIFO with a ready/valid handshake on both sides.

---
 rtl/oh_fifo_pkg.sv | 18 +
 rtl/oh_memory_ram.sv | 45 ++++
 rtl/oh_fifo_sync_dp.sv | 133 +++++++++++++
 tb/tb_oh_fifo_sync_dp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/oh_fifo_pkg.sv
// Shared FIFO helpers: pointer width and depth legality checks.
// No logic; elaboration-time constants and functions only.
// Used by the sync and async FIFO families.
package oh_fifo_pkg;

    localparam int FIFO_MIN_DEPTH = 4;

    // Pointer width: RAM address bits plus one wrap bit.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Depth must be a power of two and at least FIFO_MIN_DEPTH.
    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= FIFO_MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/oh_memory_ram.sv
// Simple dual-port RAM: one write port with per-bit write mask, one read port.
// Read latency 1 cycle; read data holds its value while rd_en is low.
// No backpressure; both ports accept a request every cycle.
module oh_memory_ram #(
    parameter int   DW    = 104,
    parameter int   DEPTH = 32,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_din,
    input  logic [DW-1:0] wr_wem,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dout
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_dout_q;
    logic [DW-1:0] rd_dout_d;

    // Masked write; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= (mem[wr_addr] & ~wr_wem) | (wr_din & wr_wem);
        end
    end

    // Read data register only updates on a read so an unconsumed word is held.
    always_comb begin
        rd_dout_d = rd_dout_q;
        if (rd_en) begin
            rd_dout_d = mem[rd_addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        rd_dout_q <= rd_dout_d;
    end

    assign rd_dout = rd_dout_q;

endmodule

// File: rtl/oh_fifo_sync_dp.sv
// Single-clock FWFT FIFO on a dual-port RAM with prefetch/output register; OH_FIFO_SYNC_BYPASS_EN enables empty bypass.
// Latency: push to out_valid is 2 cycles through the RAM, 0 extra cycles (visible after the push edge) with bypass.
// Backpressure: in_ready and out_valid are registered; in_ready = count < DEPTH, never a function of out_ready.
module oh_fifo_sync_dp
    import oh_fifo_pkg::*;
#(
    parameter int DW        = 104,
    parameter int DEPTH     = 32,
    parameter int AW        = $clog2(DEPTH),
    parameter int PROG_FULL = DEPTH - 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          prog_full
);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t DEPTH_C     = ptr_t'(DEPTH);
    localparam ptr_t PROG_FULL_C = ptr_t'(PROG_FULL);

    if (!fifo_depth_ok(DEPTH) || (fifo_ptr_w(DEPTH) != AW + 1) ||
        (PROG_FULL < 1) || (PROG_FULL > DEPTH)) begin : g_param_err
        $error("oh_fifo_sync_dp: illegal DEPTH/AW/PROG_FULL");
    end

    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          count_q,  count_d;
    logic          in_ready_q,  in_ready_d;
    logic          prog_full_q, prog_full_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          dout_vld_q,  dout_vld_d;

    logic          push, pop, out_free, dout_take, ram_ne, rd_issue, ram_wr, byp;
    logic [DW-1:0] ram_dout;

    // Handshakes and prefetch control. The RAM read register is a second
    // prefetch stage: a read is issued whenever it is free or being drained,
    // so a full output register never starves the next pop.
    always_comb begin
        push      = in_valid & in_ready_q;
        pop       = out_valid_q & out_ready;
        out_free  = ~out_valid_q | pop;
        dout_take = dout_vld_q & out_free;
        ram_ne    = (wr_ptr_q != rd_ptr_q);
        rd_issue  = ram_ne & (~dout_vld_q | dout_take);
`ifdef OH_FIFO_SYNC_BYPASS_EN
        byp       = push & out_free & ~ram_ne & ~dout_vld_q;
`else
        byp       = 1'b0;
`endif
        ram_wr    = push & ~byp;
    end

    // Next-state for pointers, occupancy, flags and the output register.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + ptr_t'(ram_wr);
        rd_ptr_d    = rd_ptr_q + ptr_t'(rd_issue);
        count_d     = count_q + ptr_t'(push) - ptr_t'(pop);
        in_ready_d  = (count_d < DEPTH_C);
        prog_full_d = (count_d >= PROG_FULL_C);
        dout_vld_d  = rd_issue | (dout_vld_q & ~dout_take);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_free) begin
            if (dout_take) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_dout;
            end else if (byp) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Control state; reset discards contents but leaves the RAM untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            prog_full_q <= 1'b0;
            out_valid_q <= 1'b0;
            dout_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            prog_full_q <= prog_full_d;
            out_valid_q <= out_valid_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    // Output data register; content is meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    oh_memory_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_din  (in_data),
        .wr_wem  ({DW{1'b1}}),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_dout (ram_dout)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign prog_full = prog_full_q;

endmodule

// File: tb/tb_oh_fifo_sync_dp.sv
// Directed vector table plus hand-written corner sequences and a scoreboard run.
// Latency expectations follow OH_FIFO_SYNC_BYPASS_EN when defined.
// Outputs are sampled 1 time unit after the rising edge.
module tb_oh_fifo_sync_dp;

    localparam int DW    = 104;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NWORDS = 12000;
`ifdef OH_FIFO_SYNC_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW:0]   count;
    logic          prog_full;

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_dat;
        int            e_cnt;
        logic          e_pf;
    } vec_t;

    vec_t tbl[$];

    oh_fifo_sync_dp dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .prog_full (prog_full)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [DW-1:0] e_dat,
                       input int e_cnt, input logic e_pf);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_dat = e_dat; v.e_cnt = e_cnt; v.e_pf = e_pf;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic e_ir, input logic e_ov,
                         input logic [DW-1:0] e_dat, input int e_cnt, input logic e_pf);
        logic ok;
        applied++;
        ok = (in_ready === e_ir) && (out_valid === e_ov) &&
             (count === (AW+1)'(e_cnt)) && (prog_full === e_pf) &&
             (!e_ov || (out_data === e_dat));
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got ir=%b ov=%b cnt=%0d pf=%b dat=%h, want ir=%b ov=%b cnt=%0d pf=%b dat=%h",
                     name, in_ready, out_valid, count, prog_full, out_data,
                     e_ir, e_ov, e_cnt, e_pf, e_dat);
        end
    endtask

    task automatic note(input string name, input bit ok, input string detail);
        applied++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Stored word sequence of the fill/stream phase: 0x1..0x20, then 0x23 onward.
    function automatic logic [DW-1:0] seqw(input int k);
        return (k < 32) ? DW'(k + 1) : DW'(35 + k - 32);
    endfunction

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] w;
        int   pushed;
        int   cyc;
        int   sz;
        logic iv;
        logic ordy;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Fill, overfill, push+pop at full, stream and drain.
        for (int i = 0; i < 32; i++)
            add(1'b1, DW'(i + 1), 1'b0, 1'b1, (i > LAT), DW'(1), i, (i >= 28));
        add(1'b1, DW'(33), 1'b0, 1'b0, 1'b1, DW'(1), 32, 1'b1);
        add(1'b0, '0,      1'b0, 1'b0, 1'b1, DW'(1), 32, 1'b1);
        add(1'b1, DW'(34), 1'b1, 1'b0, 1'b1, seqw(0), 32, 1'b1);
        for (int j = 1; j <= 40; j++)
            add(1'b1, DW'(35 + j - 1), 1'b1, 1'b1, 1'b1, seqw(j), 31, 1'b1);
        for (int d = 0; d < 31; d++)
            add(1'b0, '0, 1'b1, 1'b1, 1'b1, seqw(41 + d), 31 - d, ((31 - d) >= 28));
        add(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        add(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);

        // Reset state and release.
        tick; tick;
        check("reset", 1'b0, 1'b0, '0, 0, 1'b0);
        rst = 1'b0;
        tick;
        check("ready_rise", 1'b1, 1'b0, '0, 0, 1'b0);
        repeat (4) tick;
        check("idle_after_reset", 1'b1, 1'b0, '0, 0, 1'b0);

        for (int k = 0; k < tbl.size(); k++) begin
            in_valid  = tbl[k].iv;
            in_data   = tbl[k].id;
            out_ready = tbl[k].ordy;
            check($sformatf("vec%0d", k), tbl[k].e_ir, tbl[k].e_ov, tbl[k].e_dat,
                  tbl[k].e_cnt, tbl[k].e_pf);
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Empty-FIFO latency for a single word.
        in_valid = 1'b1; in_data = DW'(8'hAB);
        check("lat_pre", 1'b1, 1'b0, '0, 0, 1'b0);
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lat_edge_plus%0d", k), 1'b1, (k >= LAT), DW'(8'hAB), 1, 1'b0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("lat_pop", 1'b1, 1'b0, '0, 0, 1'b0);

        // Random traffic against a scoreboard.
        pushed = 0; cyc = 0;
        while ((pushed < NWORDS || q.size() != 0) && cyc < 80000) begin
            iv   = (pushed < NWORDS) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = (pushed < NWORDS) ? 1'($urandom_range(0, 1)) : 1'b1;
            w    = {8'hA5, $urandom(), $urandom(), pushed};
            in_valid = iv; in_data = w; out_ready = ordy;
            sz = q.size();
            if ((count !== (AW+1)'(sz)) || (in_ready !== (sz < DEPTH)) || (out_valid && sz == 0))
                note("rand_state", 1'b0,
                     $sformatf("cyc %0d got cnt=%0d ir=%b ov=%b, want cnt=%0d ir=%b",
                               cyc, count, in_ready, out_valid, sz, (sz < DEPTH)));
            if (out_valid && ordy) begin
                note("rand_data", out_data === q[0],
                     $sformatf("cyc %0d got %h, want %h", cyc, out_data, q[0]));
                void'(q.pop_front());
            end
            if (iv && sz < DEPTH) begin
                q.push_back(w);
                pushed++;
            end
            tick;
            cyc++;
        end
        note("rand_complete", (pushed >= NWORDS) && (q.size() == 0),
             $sformatf("pushed %0d of %0d, %0d words never emerged within %0d cycles",
                       pushed, NWORDS, q.size(), cyc));
        in_valid = 1'b0; out_ready = 1'b0;
        tick;
        check("rand_end_empty", 1'b1, 1'b0, '0, 0, 1'b0);

        // Reset mid-stream with 17 words held.
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = DW'(100 + i);
            tick;
        end
        in_valid = 1'b0;
        check("pre_rst", 1'b1, 1'b1, DW'(100), 17, 1'b0);
        rst = 1'b1;
        tick;
        check("rst_mid", 1'b0, 1'b0, '0, 0, 1'b0);
        rst = 1'b0;
        tick;
        check("rst_recover", 1'b1, 1'b0, '0, 0, 1'b0);
        in_valid = 1'b1; in_data = DW'(8'h55);
        tick;
        in_data = DW'(8'h56);
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        check("post_rst_head", 1'b1, 1'b1, DW'(8'h55), 2, 1'b0);
        out_ready = 1'b1;
        tick;
        check("post_rst_next", 1'b1, 1'b1, DW'(8'h56), 1, 1'b0);
        tick;
        out_ready = 1'b0;
        check("post_rst_empty", 1'b1, 1'b0, '0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
